// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered occupancy and status flags.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered 1-cycle read.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int                DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AF_LVL = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LVL = AE_THRESH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, cnt_q;
  logic                  ovf_q, udf_q;
  logic                  wr_acc, rd_acc;

  // Status is decoded purely from registered pointers/count, so async reset
  // reaches the flags without waiting for a clock.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                        (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign almost_full  = (cnt_q >= AF_LVL);
  assign almost_empty = (cnt_q <= AE_LVL);
  assign count        = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      case ({wr_acc, rd_acc})
        2'b10:   cnt_q <= cnt_q + ONE;
        2'b01:   cnt_q <= cnt_q - ONE;
        default: cnt_q <= cnt_q;
      endcase
      // A rejected request still pulses even if the other side was accepted.
      ovf_q <= wr_en & full;
      udf_q <= rd_en & empty;
    end
  end

  // Storage is never cleared; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
  end

`ifdef FIFO_FWFT_EN
  assign dout = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
`else
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dout_q <= '0;
    else if (rd_acc) dout_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  assign dout = dout_q;
`endif

endmodule
